textmode_pixel_pal: RTL and testbench
=====================================

TEXTMODE_PIXEL_PAL -- requirements
Module: textmode_pixel_pal

Interface
REQ-001 SHALL have parameter COLOR_BITS, default 4, bits per colour channel (legal 1..8).
REQ-002 SHALL have parameter BLINK_FRAMES, default 16, frames per blink half-period (legal 2..255, even).
REQ-003 SHALL have port clk  in  1  system clock, all logic on posedge.
REQ-004 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-005 SHALL have port pixclk  in  1  pixel enable, one-clk pulse per pixel.
REQ-006 SHALL have port attcode  in  8  [7] blink, [6:4] bg index, [3:0] fg index.
REQ-007 SHALL have port pixel  in  1  glyph bit, 1 = foreground.
REQ-008 SHALL have port visible  in  1  1 = active video, 0 = force black.
REQ-009 SHALL have port cursor  in  1  current cell and scanline are cursor.
REQ-010 SHALL have ports hsync_in, vsync_in  in  1 each  timing syncs, polarity passed through.
REQ-011 SHALL have ports pal_we  in  1, pal_addr  in  4, pal_data  in  3*COLOR_BITS  palette write, data {r,g,b}.
REQ-012 SHALL have ports hsync, vsync  out  1 each; r, g, b  out  COLOR_BITS each.

Function
REQ-013 All pipeline/output registers SHALL advance only in clk cycles with pixclk=1; otherwise hold.
REQ-014 Stage 1 SHALL register index, visible, hsync_in, vsync_in; stage 2 SHALL register palette[index] (or 0) and syncs to outputs; latency exactly 2 pixclk pulses, syncs aligned with colour.
REQ-015 Foreground SHALL be fg = (pixel & ~(attcode[7] & blink_phase)) | (cursor & ~blink_phase).
REQ-016 Index SHALL be attcode[3:0] when fg, else {1'b0, attcode[6:4]}.
REQ-017 Output colour SHALL be palette entry when staged visible=1, else r=g=b=0.
REQ-018 Blink counter SHALL increment on each rising edge of vsync_in detected between consecutive pixclk samples; at BLINK_FRAMES-1 it SHALL wrap to 0 and toggle blink_phase.
REQ-019 Palette SHALL hold 16 entries of 3*COLOR_BITS; reads combinational within stage 2.
REQ-020 Write and stage-2 read of same entry in same clk SHALL yield old value; new value from next clk.
REQ-021 Palette writes SHALL occur on any clk with pal_we=1, independent of pixclk.

Reset
REQ-022 rst_n=0 SHALL immediately clear hsync, vsync, r, g, b, both stages, blink counter, blink_phase, vsync edge detector.
REQ-023 Palette SHALL reset to default: entry i, channel bit c (r=2,g=1,b=0): level = i[c] ? (i[3] ? MAX : 2*MAX/3) : (i[3] ? MAX/3 : 0), MAX = 2^COLOR_BITS-1, integer division.
REQ-024 Reset release mid-frame SHALL need no resync; first output valid after 2 pixclk pulses.

Configuration
REQ-025 With TEXTMODE_PALETTE_WRITE_EN defined, palette SHALL be registers with REQ-020/021 write behaviour.
REQ-026 Without it, palette SHALL be constant default table (REQ-023); pal_* ports present but ignored.

Structure
REQ-027 Package textmode_pkg SHALL hold attribute bit-position constants, palette depth 16, and default-palette function of COLOR_BITS.
REQ-028 Palette storage SHALL be sub-module textmode_palette (write port, async read, reset defaults, macro-gated).

Verification
REQ-029 COLOR_BITS=4, attcode=8'h1E, pixel=1, visible=1, pixclk every 2nd clk -> after 2 pulses r=15,g=15,b=5.
REQ-030 Same, pixel=0 -> r=0,g=0,b=10; visible=0 -> 0,0,0 with syncs still delayed 2 pulses.
REQ-031 attcode=8'h87, pixel=1, 16 vsync_in rising edges -> blink_phase=1, output bg (0,0,0); after 16 more -> fg (10,10,10).
REQ-032 cursor=1, pixel=0, attcode=8'h07, blink_phase=0 -> fg (10,10,10); blink_phase=1 -> bg (0,0,0).
REQ-033 WRITE_EN: pal_we=1, pal_addr=7, pal_data=12'h123 same clk as stage-2 read of 7 -> old (10,10,10); next pixel -> (1,2,3); without macro -> unchanged.
REQ-034 rst_n low mid-line with pipeline full -> all outputs 0 same cycle; palette and blink counter at defaults.

Source files
------------

// File: rtl/textmode_pkg.sv
// Shared constants and the default palette for the text-mode pixel pipeline.
package textmode_pkg;

    // Attribute byte layout
    localparam int unsigned AttBlinkBit = 7;
    localparam int unsigned AttBgMsb    = 6;
    localparam int unsigned AttBgLsb    = 4;
    localparam int unsigned AttFgMsb    = 3;
    localparam int unsigned AttFgLsb    = 0;

    localparam int unsigned PalDepth = 16;
    localparam int unsigned PalIdxW  = 4;

    // CGA-style level for one channel: bit set -> bright or 2/3, clear -> 1/3 or off.
    function automatic int unsigned default_level(int unsigned color_bits, logic [3:0] idx,
                                                  int unsigned chan);
        int unsigned max_v;
        max_v = (1 << color_bits) - 1;
        if (idx[chan]) return idx[3] ? max_v : (2 * max_v) / 3;
        return idx[3] ? max_v / 3 : 0;
    endfunction

    // Packed {r,g,b} default entry, b in the low ColorBits.
    function automatic logic [23:0] default_entry(int unsigned color_bits, logic [3:0] idx);
        logic [23:0] e;
        e = '0;
        for (int unsigned c = 0; c < 3; c++) begin
            e = e | (24'(default_level(color_bits, idx, c)) << (c * color_bits));
        end
        return e;
    endfunction

endpackage

// File: rtl/textmode_palette.sv
// 16-entry colour palette with async read. Writable registers when
// TEXTMODE_PALETTE_WRITE_EN is defined, otherwise a constant default table.
module textmode_palette
    import textmode_pkg::*;
#(
    parameter int unsigned ColorBits = 4,
    parameter int unsigned DataW     = 3 * ColorBits
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               we_i,
    input  logic [PalIdxW-1:0] waddr_i,
    input  logic [DataW-1:0]   wdata_i,
    input  logic [PalIdxW-1:0] raddr_i,
    output logic [DataW-1:0]   rdata_o
);

    logic [DataW-1:0] def_tbl [PalDepth];

    for (genvar gi = 0; gi < PalDepth; gi++) begin : g_def
        assign def_tbl[gi] = DataW'(default_entry(ColorBits, 4'(gi)));
    end

`ifdef TEXTMODE_PALETTE_WRITE_EN
    logic [DataW-1:0] mem_q [PalDepth];

    // Palette storage: reset to defaults, written on any clk regardless of pixclk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PalDepth; i++) mem_q[i] <= def_tbl[i];
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read sees the pre-write value in the write cycle
    assign rdata_o = mem_q[raddr_i];
`else
    logic unused_wr;
    assign unused_wr = ^{clk, rst_n, we_i, waddr_i, wdata_i};
    assign rdata_o   = def_tbl[raddr_i];
`endif

endmodule

// File: rtl/textmode_pixel_pal.sv
// Text-mode attribute/palette pixel pipeline: two pixclk-gated stages with
// blink handling. Optional palette writes via TEXTMODE_PALETTE_WRITE_EN.
module textmode_pixel_pal
    import textmode_pkg::*;
#(
    parameter int unsigned COLOR_BITS   = 4,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    pixclk,
    input  logic [7:0]              attcode,
    input  logic                    pixel,
    input  logic                    visible,
    input  logic                    cursor,
    input  logic                    hsync_in,
    input  logic                    vsync_in,
    input  logic                    pal_we,
    input  logic [3:0]              pal_addr,
    input  logic [3*COLOR_BITS-1:0] pal_data,
    output logic                    hsync,
    output logic                    vsync,
    output logic [COLOR_BITS-1:0]   r,
    output logic [COLOR_BITS-1:0]   g,
    output logic [COLOR_BITS-1:0]   b
);

    localparam int unsigned DataW = 3 * COLOR_BITS;

    logic [PalIdxW-1:0] s1_idx_q, s1_idx_d;
    logic               s1_vis_q, s1_hs_q, s1_vs_q;
    logic               vs_prev_q;
    logic [7:0]         blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               fg;
    logic               vs_rise;
    logic [DataW-1:0]   pal_rdata;
    logic [DataW-1:0]   col_d, col_q;
    logic               hs_q, vs_q;

    textmode_palette #(
        .ColorBits(COLOR_BITS)
    ) u_palette (
        .clk    (clk),
        .rst_n  (rst_n),
        .we_i   (pal_we),
        .waddr_i(pal_addr),
        .wdata_i(pal_data),
        .raddr_i(s1_idx_q),
        .rdata_o(pal_rdata)
    );

    // Foreground select, palette index and blink counter next state
    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        fg = (pixel & ~(attcode[AttBlinkBit] & blink_phase_q)) | (cursor & ~blink_phase_q);
        s1_idx_d = fg ? attcode[AttFgMsb:AttFgLsb] : {1'b0, attcode[AttBgMsb:AttBgLsb]};
        vs_rise  = vsync_in & ~vs_prev_q;
        if (vs_rise) begin
            if (blink_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
        col_d = s1_vis_q ? pal_rdata : '0;
    end

    // Pipeline stages and blink state, all advanced only on pixel enables
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_idx_q      <= '0;
            s1_vis_q      <= 1'b0;
            s1_hs_q       <= 1'b0;
            s1_vs_q       <= 1'b0;
            vs_prev_q     <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            col_q         <= '0;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
        end else if (pixclk) begin
            s1_idx_q      <= s1_idx_d;
            s1_vis_q      <= visible;
            s1_hs_q       <= hsync_in;
            s1_vs_q       <= vsync_in;
            vs_prev_q     <= vsync_in;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            col_q         <= col_d;
            hs_q          <= s1_hs_q;
            vs_q          <= s1_vs_q;
        end
    end

    assign hsync = hs_q;
    assign vsync = vs_q;
    assign r     = col_q[2*COLOR_BITS +: COLOR_BITS];
    assign g     = col_q[COLOR_BITS +: COLOR_BITS];
    assign b     = col_q[0 +: COLOR_BITS];

endmodule

// File: tb/tb_textmode_pixel_pal.sv
// Scoreboard bench for textmode_pixel_pal (COLOR_BITS=4, BLINK_FRAMES=16).
module tb_textmode_pixel_pal;

    localparam int unsigned Cb = 4;
    localparam int unsigned Bf = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pixclk = 1'b0;
    logic [7:0]    attcode = '0;
    logic          pixel = 1'b0, visible = 1'b0, cursor = 1'b0;
    logic          hsync_in = 1'b0, vsync_in = 1'b0;
    logic          pal_we = 1'b0;
    logic [3:0]    pal_addr = '0;
    logic [11:0]   pal_data = '0;
    logic          hsync, vsync;
    logic [Cb-1:0] r, g, b;

    textmode_pixel_pal #(
        .COLOR_BITS  (Cb),
        .BLINK_FRAMES(Bf)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pixclk  (pixclk),
        .attcode (attcode),
        .pixel   (pixel),
        .visible (visible),
        .cursor  (cursor),
        .hsync_in(hsync_in),
        .vsync_in(vsync_in),
        .pal_we  (pal_we),
        .pal_addr(pal_addr),
        .pal_data(pal_data),
        .hsync   (hsync),
        .vsync   (vsync),
        .r       (r),
        .g       (g),
        .b       (b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] idx;
        logic       vis;
        logic       hs;
        logic       vs;
    } sb_entry_t;

    sb_entry_t   sb[$];
    logic [11:0] pal_m [16];
    int          edges;
    logic        prev_vs;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] lvl(input logic [3:0] i, input int c);
        if (i[c]) return i[3] ? 4'd15 : 4'd10;
        return i[3] ? 4'd5 : 4'd0;
    endfunction

    task automatic model_reset();
        sb.delete();
        edges   = 0;
        prev_vs = 1'b0;
        for (int i = 0; i < 16; i++) pal_m[i] = {lvl(4'(i), 2), lvl(4'(i), 1), lvl(4'(i), 0)};
    endtask

    function automatic logic [31:0] outs();
        return 32'({hsync, vsync, r, g, b});
    endfunction

    // One pixel: drive on a pixclk pulse, then an idle clk to check hold behaviour
    task automatic pix(input string tag, input logic [7:0] att, input logic p, input logic vis,
                       input logic cur, input logic hs, input logic vs, input logic we,
                       input logic [3:0] wa, input logic [11:0] wd);
        logic      phase, fgm, have;
        sb_entry_t e;
        logic [31:0] exp;
        @(negedge clk);
        attcode = att; pixel = p; visible = vis; cursor = cur;
        hsync_in = hs; vsync_in = vs; pixclk = 1'b1;
        pal_we = we; pal_addr = wa; pal_data = wd;
        phase = ((edges / Bf) % 2) == 1;
        fgm   = (p & ~(att[7] & phase)) | (cur & ~phase);
        e.idx = fgm ? att[3:0] : {1'b0, att[6:4]};
        e.vis = vis; e.hs = hs; e.vs = vs;
        sb.push_back(e);
        if (vs && !prev_vs) edges++;
        prev_vs = vs;
        have = 1'b0;
        exp  = '0;
        if (sb.size() > 1) begin
            e    = sb.pop_front();
            exp  = 32'({e.hs, e.vs, (e.vis ? pal_m[e.idx] : 12'h000)});
            have = 1'b1;
        end
`ifdef TEXTMODE_PALETTE_WRITE_EN
        if (we) pal_m[wa] = wd;
`endif
        @(posedge clk); #1;
        if (have) check(tag, outs(), exp);
        @(negedge clk);
        pixclk = 1'b0; pal_we = 1'b0;
        @(posedge clk); #1;
        if (have) check({tag, "_hold"}, outs(), exp);
    endtask

    task automatic vs_edges(input int n, input logic [7:0] att);
        for (int i = 0; i < n; i++) begin
            pix("blink_vs0", att, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h0);
            pix("blink_vs1", att, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 12'h0);
        end
    endtask

    initial begin
        model_reset();
        #1;
        check("reset_out", outs(), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // fg/bg/visible with sync patterns
        for (int i = 0; i < 4; i++)
            pix("fg_1e", 8'h1E, 1'b1, 1'b1, 1'b0, 1'(i), 1'(i >> 1), 1'b0, 4'd0, 12'h0);
        for (int i = 0; i < 3; i++)
            pix("bg_1e", 8'h1E, 1'b0, 1'b1, 1'b0, 1'(i + 1), 1'b0, 1'b0, 4'd0, 12'h0);
        for (int i = 0; i < 4; i++)
            pix("invis", 8'h1E, 1'b1, 1'b0, 1'b0, 1'(i >> 1), 1'(i), 1'b0, 4'd0, 12'h0);
        for (int i = 0; i < 3; i++)
            pix("cursor_p0", 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 12'h0);

        // Blink: 16 edges flip phase, 16 more flip it back
        vs_edges(16, 8'h87);
        for (int i = 0; i < 3; i++)
            pix("blink_bg", 8'h87, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h0);
        for (int i = 0; i < 3; i++)
            pix("cursor_p1", 8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 12'h0);
        vs_edges(16, 8'h87);
        for (int i = 0; i < 3; i++)
            pix("blink_fg", 8'h87, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h0);

        // Write entry 7 in the clk that reads it at stage 2
        pix("wr_pre", 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h0);
        pix("wr_old", 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 12'h123);
        pix("wr_new", 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 12'h0);
        pix("wr_new2", 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 12'h0);

        // Random traffic with occasional palette writes
        for (int i = 0; i < 40; i++)
            pix("rand", 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
                1'($urandom_range(0, 5) == 0), 4'($urandom), 12'($urandom));

        // Leave blink phase at 1 and the pipeline full, then reset mid-line
        vs_edges(16, 8'h87);
        pix("pre_rst", 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0);
        pix("pre_rst", 8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 12'h0);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async", outs(), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++)
            pix("post_rst_fg", 8'h87, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 12'h0);
        for (int i = 0; i < 3; i++)
            pix("post_rst_pal7", 8'h07, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 12'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
